ct_read_arbiter: RTL and testbench
==================================

// Module: ct_read_arbiter
// PURPOSE
//  Round-robin arbiter that shares the single read port of ct_mem among NUM_REQ crack engines.
//  Each engine posts a read request with an address. The arbiter issues at most one read per cycle
//  and returns the read data to the winning engine, tagged by a one-hot valid.
//  An optional lock lets one engine take consecutive reads, for example a full ciphertext pass.
//  The lock is bounded by MAX_BURST, so no engine starves.
// PARAMETERS
//  NUM_REQ    4   number of requesters (>=1, need not be a power of 2)
//  ADDR_W     8   ct_mem address width
//  DATA_W     8   ct_mem data width
//  MAX_BURST  16  max consecutive grants to a locked owner; 0 = unlimited
// PORTS
//  clk        in   1                 system clock; the block has one clock
//  rst        in   1                 reset, asynchronous and active-high
//  req        in   NUM_REQ           per-requester read request; held until granted
//  lock       in   NUM_REQ           per-requester burst-lock request; sampled with req
//  req_addr   in   NUM_REQ*ADDR_W    requester i address at [i*ADDR_W +: ADDR_W]
//  gnt        out  NUM_REQ           one-hot grant; read accepted this cycle
//  rd_valid   out  NUM_REQ           one-hot; rd_data belongs to requester i this cycle
//  rd_data    out  DATA_W            read data, equal to ct_rddata
//  ct_addr    out  ADDR_W            ct_mem address
//  ct_rddata  in   DATA_W            ct_mem q (1-cycle synchronous read)
//  busy       out  1                 high when LOCKED or a read is in flight
// BEHAVIOUR
//  - Reset (async, rst=1):
//    - state=ARB, ptr=0, owner=0, burst_cnt=0.
//    - rd_valid=0, busy=0.
//    - gnt is forced to 0 and ct_addr to 0 while rst is high, whatever req is.
//  - Grant path:
//    - gnt and ct_addr are combinational from req, lock and the state registers.
//    - ct_addr = req_addr[winner]; ct_addr = 0 when there is no winner.
//    - ct_mem samples ct_addr on the clk edge.
//  - Return path:
//    - rd_valid <= gnt (registered), so it rises exactly 1 cycle after gnt.
//    - rd_data = ct_rddata (combinational passthrough), aligned with rd_valid.
//    - Throughput is 1 read per cycle. Back-to-back grants to different requesters are legal.
//  - Handshake:
//    - A requester holds req, req_addr and lock stable until it sees gnt.
//    - gnt is a 1-cycle acceptance of that address.
//    - After gnt, the requester may keep req high with a new address to chain reads.
//  - State ARB:
//    - winner = first set req[k], scanning k = ptr, ptr+1, ..., wrapping NUM_REQ-1 -> 0.
//    - On a grant to i: ptr <= (i==NUM_REQ-1) ? 0 : i+1.
//    - If lock[i]=1 at the grant: state <= LOCKED, owner <= i, burst_cnt <= 1.
//  - State LOCKED:
//    - Only owner is eligible; other requests wait with gnt=0.
//    - If req[owner] & lock[owner]: grant owner and increment burst_cnt.
//    - If lock[owner]=0, that same cycle arbitrates as ARB with ptr=owner+1. A req from owner is
//      then eligible with lowest priority. state <= ARB.
//    - Owner holds lock with req low (idle but locked): no grant, stay LOCKED.
//    - If MAX_BURST!=0 and burst_cnt==MAX_BURST: owner is ineligible this cycle. Arbitrate as ARB
//      with ptr=owner+1, state <= ARB. Owner may re-lock when next granted.
//  - Widths:
//    - ptr and owner are $clog2(NUM_REQ) bits, with a minimum of 1.
//    - burst_cnt is $clog2(MAX_BURST+1) bits and never wraps.
//  - NUM_REQ=1: requester 0 is granted whenever req[0]=1; the lock bound still applies.
//  - Reset mid-read: an in-flight rd_valid is dropped and is not replayed; requesters re-request.
//  - busy = (state==LOCKED) | (|rd_valid).
// TESTING
//  1. Reset: req=4'b1111 and rst pulsed mid-stream -> gnt=0 and rd_valid=0 during rst;
//     first grant after release is 4'b0001.
//  2. Round robin, NUM_REQ=4, req=4'b1111, lock=0 -> gnt cycles 0001,0010,0100,1000,0001;
//     rd_valid is the same sequence one cycle later; rd_data=mem[req_addr] each cycle.
//  3. Lock: req=4'b0111 with lock[1]=1 granted first -> gnt=0010 on consecutive cycles while
//     lock[1]=1; the cycle lock[1] drops, gnt=0100.
//  4. Burst bound, MAX_BURST=16: req1 locked for 20 cycles, req3 waiting -> exactly 16 grants of
//     0010, then one grant of 1000, then 0010 again (re-lock).
//  5. Single requester: only req[2], addresses 0..255 chained -> gnt=0100 every cycle;
//     rd_valid[2] stream returns mem[0..255] in order; ct_addr wraps 255->0 cleanly.
//  6. NUM_REQ=3, req=3'b111 -> gnt 001,010,100,001 (pointer wraps 2->0); no grant of the
//     unused 4th index.

Source files
------------

// File: rtl/ct_read_arbiter.sv
// Round-robin arbiter sharing the single ct_mem read port among NUM_REQ crack engines,
// with a bounded burst lock and a registered one-hot return tag aligned to ct_rddata.
module ct_read_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        lock,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rd_valid,
    output logic [DATA_W-1:0]         rd_data,
    output logic [ADDR_W-1:0]         ct_addr,
    input  logic [DATA_W-1:0]         ct_rddata,
    output logic                      busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t             state, state_nxt;
    logic [PTR_W-1:0]   ptr, ptr_nxt;
    logic [PTR_W-1:0]   owner, owner_nxt;
    logic [CNT_W-1:0]   burst_cnt, burst_cnt_nxt;
    logic [NUM_REQ-1:0] vld_p1;

    logic [NUM_REQ-1:0] owner_mask;
    logic [NUM_REQ-1:0] elig;
    logic [PTR_W-1:0]   scan_ptr;
    logic [PTR_W-1:0]   win;
    logic               found;
    logic               bound_hit;
    logic [NUM_REQ-1:0] gnt_raw;
    logic [ADDR_W-1:0]  addr_raw;
    int                 idx;

    // Next requester index, wrapping NUM_REQ-1 -> 0 (NUM_REQ need not be a power of 2).
    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        if (int'(p) >= NUM_REQ - 1)
            return '0;
        return p + PTR_W'(1);
    endfunction

    // Burst counter increment that saturates instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        if ((MAX_BURST != 0) && (int'(c) >= MAX_BURST))
            return c;
        if (&c)
            return c;
        return c + CNT_W'(1);
    endfunction

    assign owner_mask = NUM_REQ'(1) << owner;
    assign bound_hit  = (MAX_BURST != 0) && (int'(burst_cnt) >= MAX_BURST);

    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        owner_nxt     = owner;
        burst_cnt_nxt = burst_cnt;
        elig          = req;
        scan_ptr      = ptr;
        found         = 1'b0;
        win           = '0;
        gnt_raw       = '0;
        addr_raw      = '0;
        idx           = 0;

        // A locked owner either keeps exclusive access or hands over with lowest priority.
        if (state == LOCKED) begin
            if (bound_hit) begin
                elig          = req & ~owner_mask;
                scan_ptr      = wrap_inc(owner);
                ptr_nxt       = wrap_inc(owner);
                state_nxt     = ARB;
                burst_cnt_nxt = '0;
            end else if (!lock[owner]) begin
                scan_ptr      = wrap_inc(owner);
                ptr_nxt       = wrap_inc(owner);
                state_nxt     = ARB;
                burst_cnt_nxt = '0;
            end else begin
                elig     = req & owner_mask;
                scan_ptr = owner;
            end
        end

        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(scan_ptr) + k;
            if (idx >= NUM_REQ)
                idx = idx - NUM_REQ;
            if (!found && elig[idx[PTR_W-1:0]]) begin
                found = 1'b1;
                win   = idx[PTR_W-1:0];
            end
        end

        if (found) begin
            gnt_raw[win] = 1'b1;
            addr_raw     = req_addr[int'(win)*ADDR_W +: ADDR_W];
            ptr_nxt      = wrap_inc(win);
            if ((state == LOCKED) && (state_nxt == LOCKED)) begin
                burst_cnt_nxt = sat_inc(burst_cnt);
            end else if (lock[win]) begin
                state_nxt     = LOCKED;
                owner_nxt     = win;
                burst_cnt_nxt = CNT_W'(1);
            end
        end
    end

    assign gnt     = rst ? '0 : gnt_raw;
    assign ct_addr = rst ? '0 : addr_raw;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ARB;
            ptr       <= '0;
            owner     <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            owner     <= owner_nxt;
            burst_cnt <= burst_cnt_nxt;
        end
    end

    // Stage p1: ct_mem returns data one cycle after the grant; tag it with the winner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            vld_p1 <= '0;
        else
            vld_p1 <= gnt;
    end

    assign rd_valid = vld_p1;
    assign rd_data  = ct_rddata;
    assign busy     = (state == LOCKED) | (|vld_p1);

endmodule

// File: tb/tb_ct_read_arbiter.sv
// Scoreboard bench for ct_read_arbiter: directed stimulus pushes expected grants/returns,
// negedge monitors pop and compare against a 4-requester and a 3-requester instance.
module tb_ct_read_arbiter;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int MB = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req, lock, gnt, rd_valid;
    logic [N*AW-1:0] req_addr;
    logic [DW-1:0]   rd_data, ct_rddata;
    logic [AW-1:0]   ct_addr;
    logic            busy;

    logic [2:0]      req3, lock3, gnt3, rd_valid3;
    logic [3*AW-1:0] req_addr3;
    logic [DW-1:0]   rd_data3, ct_rddata3;
    logic [AW-1:0]   ct_addr3;
    logic            busy3;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [3:0] gnt;
        logic [7:0] addr;
    } gexp_t;

    typedef struct {
        logic [3:0] vld;
        logic [7:0] data;
        int         cyc;
    } rexp_t;

    gexp_t gq[$];
    gexp_t gq3[$];
    rexp_t rq[$];
    rexp_t rq3[$];
    gexp_t ge, ge3;
    rexp_t re, re3;

    ct_read_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst), .req(req), .lock(lock), .req_addr(req_addr),
        .gnt(gnt), .rd_valid(rd_valid), .rd_data(rd_data), .ct_addr(ct_addr),
        .ct_rddata(ct_rddata), .busy(busy)
    );

    ct_read_arbiter #(.NUM_REQ(3), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut3 (
        .clk(clk), .rst(rst), .req(req3), .lock(lock3), .req_addr(req_addr3),
        .gnt(gnt3), .rd_valid(rd_valid3), .rd_data(rd_data3), .ct_addr(ct_addr3),
        .ct_rddata(ct_rddata3), .busy(busy3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] mem_f(input logic [7:0] a);
        return {a[3:0], a[7:4]} ^ 8'h3C;
    endfunction

    // ct_mem model: one-cycle synchronous read
    always @(posedge clk) begin
        ct_rddata  <= mem_f(ct_addr);
        ct_rddata3 <= mem_f(ct_addr3);
    end

    function automatic logic [7:0] addr_of(input logic [7:0] base, input int i);
        return base + 8'(i * 64);
    endfunction

    function automatic int oh_idx(input logic [3:0] oh);
        for (int i = 0; i < 4; i++)
            if (oh[i]) return i;
        return 0;
    endfunction

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic do_reset(input int n, input logic [3:0] r);
        repeat (n) begin
            @(posedge clk); #1;
            rst  = 1'b1;
            req  = r;
            lock = '0;
            rq.delete();
            rq3.delete();
            gq.push_back('{4'b0000, 8'h00});
        end
    endtask

    task automatic drive(input logic [3:0] r, input logic [3:0] l, input logic [3:0] eg,
                         input logic [7:0] base);
        logic [7:0] a;
        @(posedge clk); #1;
        rst  = 1'b0;
        req  = r;
        lock = l;
        for (int i = 0; i < N; i++)
            req_addr[i*AW +: AW] = addr_of(base, i);
        a = (eg != 4'b0000) ? addr_of(base, oh_idx(eg)) : 8'h00;
        gq.push_back('{eg, a});
        if (eg != 4'b0000)
            rq.push_back('{eg, mem_f(a), cyc + 1});
    endtask

    task automatic drive3(input logic [2:0] r, input logic [2:0] eg, input logic [7:0] base);
        logic [7:0] a;
        @(posedge clk); #1;
        rst   = 1'b0;
        req3  = r;
        lock3 = '0;
        for (int i = 0; i < 3; i++)
            req_addr3[i*AW +: AW] = addr_of(base, i);
        a = (eg != 3'b000) ? addr_of(base, oh_idx({1'b0, eg})) : 8'h00;
        gq3.push_back('{{1'b0, eg}, a});
        if (eg != 3'b000)
            rq3.push_back('{{1'b0, eg}, mem_f(a), cyc + 1});
    endtask

    always @(negedge clk) begin
        if (gq.size() > 0) begin
            ge = gq.pop_front();
            chk(gnt === ge.gnt, "gnt", 32'(gnt), 32'(ge.gnt));
            chk(ct_addr === ge.addr, "ct_addr", 32'(ct_addr), 32'(ge.addr));
        end
        if (rst === 1'b1)
            chk((rd_valid === 4'b0000) && (busy === 1'b0), "rst_outputs", {rd_valid, busy}, 32'h0);
        if (rd_valid !== 4'b0000) begin
            chk(rq.size() > 0, "rd_unexpected", 32'(rd_valid), 32'h0);
            if (rq.size() > 0) begin
                re = rq.pop_front();
                chk((rd_valid === re.vld) && (rd_data === re.data) && (cyc == re.cyc), "rd_return",
                    {4'(cyc), rd_valid, rd_data}, {4'(re.cyc), re.vld, re.data});
            end
        end
    end

    always @(negedge clk) begin
        if (gq3.size() > 0) begin
            ge3 = gq3.pop_front();
            chk({1'b0, gnt3} === ge3.gnt, "gnt_n3", 32'(gnt3), 32'(ge3.gnt));
            chk(ct_addr3 === ge3.addr, "ct_addr_n3", 32'(ct_addr3), 32'(ge3.addr));
        end
        if (rd_valid3 !== 3'b000) begin
            chk(rq3.size() > 0, "rd_unexpected_n3", 32'(rd_valid3), 32'h0);
            if (rq3.size() > 0) begin
                re3 = rq3.pop_front();
                chk(({1'b0, rd_valid3} === re3.vld) && (rd_data3 === re3.data) && (cyc == re3.cyc),
                    "rd_return_n3", {4'(cyc), 1'b0, rd_valid3, rd_data3}, {4'(re3.cyc), re3.vld, re3.data});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        req       = 4'b1111;
        lock      = '0;
        req_addr  = '0;
        req3      = '0;
        lock3     = '0;
        req_addr3 = '0;

        // reset with all requests pending, then a mid-stream reset
        do_reset(3, 4'b1111);
        drive(4'b1111, 4'b0000, 4'b0001, 8'h11);
        drive(4'b1111, 4'b0000, 4'b0010, 8'h12);
        do_reset(2, 4'b1111);

        // plain round robin
        drive(4'b1111, 4'b0000, 4'b0001, 8'h20);
        drive(4'b1111, 4'b0000, 4'b0010, 8'h21);
        drive(4'b1111, 4'b0000, 4'b0100, 8'h22);
        drive(4'b1111, 4'b0000, 4'b1000, 8'h23);
        drive(4'b1111, 4'b0000, 4'b0001, 8'h24);

        // lock by requester 1 (pointer now at 1), idle-but-locked, then release
        drive(4'b0111, 4'b0010, 4'b0010, 8'h30);
        drive(4'b0111, 4'b0010, 4'b0010, 8'h31);
        drive(4'b0101, 4'b0010, 4'b0000, 8'h32);
        drive(4'b0111, 4'b0010, 4'b0010, 8'h33);
        drive(4'b0111, 4'b0000, 4'b0100, 8'h34);
        drive(4'b0111, 4'b0000, 4'b0001, 8'h35);
        drive(4'b0111, 4'b0000, 4'b0010, 8'h36);

        // burst bound: 16 locked grants, one to the waiter, then re-lock
        do_reset(1, 4'b0000);
        for (int k = 0; k < 16; k++)
            drive(4'b1010, 4'b0010, 4'b0010, 8'(k));
        drive(4'b1010, 4'b0010, 4'b1000, 8'h50);
        for (int k = 0; k < 3; k++)
            drive(4'b1010, 4'b0010, 4'b0010, 8'(8'h60 + k));

        // single requester chaining addresses 0..255 and wrapping to 0
        do_reset(1, 4'b0000);
        for (int k = 0; k <= 256; k++)
            drive(4'b0100, 4'b0000, 4'b0100, 8'(k) - 8'd128);

        // three requesters: pointer wraps 2 -> 0
        do_reset(1, 4'b0000);
        drive3(3'b111, 3'b001, 8'h70);
        drive3(3'b111, 3'b010, 8'h71);
        drive3(3'b111, 3'b100, 8'h72);
        drive3(3'b111, 3'b001, 8'h73);
        @(posedge clk); #1;
        req3 = '0;
        repeat (3) @(posedge clk);
        #1;

        chk((gq.size() + gq3.size() + rq.size() + rq3.size()) == 0, "drain",
            32'(gq.size() + gq3.size() + rq.size() + rq3.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
